// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receive FIFO: pop/enable/clear strobes in,
// head byte, fill level, interrupt and sticky error flags out.
interface uart_rx_fifo_if #(
  parameter int FIFO_AW = 2
);
  logic               rd_en;
  logic               irq_en;
  logic               err_clr;
  logic [7:0]         rd_data;
  logic [FIFO_AW:0]   count;
  logic               int0;
  logic               overrun;
  logic               frame_err;

  modport master (
    output rd_en, irq_en, err_clr,
    input  rd_data, count, int0, overrun, frame_err
  );

  modport slave (
    input  rd_en, irq_en, err_clr,
    output rd_data, count, int0, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a small show-ahead FIFO with level interrupt
// and sticky overrun / framing-error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uart_in,
  uart_rx_fifo_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  localparam int               CW        = $clog2(CLKS_PER_BIT);
  localparam int               DEPTH_I   = 1 << FIFO_AW;
  localparam logic [CW-1:0]    LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] DEPTH     = {1'b1, {FIFO_AW{1'b0}}};

  logic                 sync1_reg;
  logic                 rxs_reg;
  state_t               state_reg;
  state_t               state_next;
  logic [CW-1:0]        sample_cnt_reg;
  logic [2:0]           bit_cnt_reg;
  logic [7:0]           shift_reg;
  logic                 half_tick;
  logic                 bit_tick;
  logic                 push;
  logic                 frame_set;

  logic [7:0]           mem [DEPTH_I];
  logic [FIFO_AW-1:0]   wr_ptr_reg;
  logic [FIFO_AW-1:0]   rd_ptr_reg;
  logic [FIFO_AW:0]     count_reg;
  logic                 overrun_reg;
  logic                 frame_err_reg;
  logic                 pop_ok;
  logic                 do_write;
  logic                 full;

  // Two-flop synchroniser; both flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= uart_in;
      rxs_reg   <= sync1_reg;
    end
  end

  assign half_tick = (sample_cnt_reg == HALF_LAST);
  assign bit_tick  = (sample_cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (!rxs_reg) state_next = ST_START;
      ST_START:     if (half_tick) state_next = rxs_reg ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_tick && bit_cnt_reg == 3'd7) state_next = ST_STOP;
      ST_STOP:      if (bit_tick) state_next = rxs_reg ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rxs_reg) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state_reg == ST_STOP && bit_tick) begin
      push      = rxs_reg;
      frame_set = !rxs_reg;
    end
  end

  // Sample counter restarts on every state change and every full bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
    end else begin
      if (state_reg == ST_IDLE || state_reg == ST_WAIT_HIGH ||
          state_next != state_reg || bit_tick)
        sample_cnt_reg <= '0;
      else
        sample_cnt_reg <= sample_cnt_reg + 1'b1;

      if (state_reg == ST_DATA) begin
        if (bit_tick) begin
          shift_reg[bit_cnt_reg] <= rxs_reg;
          bit_cnt_reg            <= bit_cnt_reg + 1'b1;
        end
      end else begin
        bit_cnt_reg <= '0;
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign full     = (count_reg == DEPTH);
  assign pop_ok   = bus.rd_en && (count_reg != '0);
  assign do_write = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{FIFO_AW{1'b0}}, do_write}
                             - {{FIFO_AW{1'b0}}, pop_ok};

      if (push && full && !pop_ok) overrun_reg <= 1'b1;
      else if (bus.err_clr)        overrun_reg <= 1'b0;

      if (frame_set)          frame_err_reg <= 1'b1;
      else if (bus.err_clr)   frame_err_reg <= 1'b0;
    end
  end

  assign bus.rd_data   = (count_reg != '0) ? mem[rd_ptr_reg] : 8'h00;
  assign bus.count     = count_reg;
  assign bus.int0      = bus.irq_en && (count_reg != '0);
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table plus hand-written corner
// sequences, with a byte queue as the expected-data scoreboard.
module tb_uart_rx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;

  typedef struct {
    logic [7:0] data;
    logic [2:0] exp_count;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic uart_in;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[5];

  uart_rx_fifo_if #(.FIFO_AW(AW)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_in (uart_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop level; the line is left
  // at the stop level and the next posedge is the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
    repeat (CPB) @(negedge clk);
    if (exp_q.size() < (1 << AW)) exp_q.push_back(d);
    $display("tx byte 0x%02h, queued %0d", d, exp_q.size());
  endtask

  task automatic read_byte(input string name);
    logic [7:0] exp;
    exp = 8'h00;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check(name, bus.rd_data, exp);
    $display("rd byte 0x%02h (want 0x%02h)", bus.rd_data, exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h01, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 3'd3, 1'b0, 1'b0};
    vecs[3] = '{8'h04, 3'd4, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 3'd4, 1'b1, 1'b0};

    uart_in     = 1'b1;
    rst         = 1'b1;
    bus.rd_en   = 1'b0;
    bus.irq_en  = 1'b1;
    bus.err_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_count", bus.count, 0);
    check("reset_int0", bus.int0, 0);
    check("reset_rd_data", bus.rd_data, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_frame_err", bus.frame_err, 0);
    repeat (4) @(negedge clk);

    // Single frame with latency check.
    send_frame(8'hA5, 1'b1);
    check("a5_before_push", bus.count, 0);
    @(negedge clk);
    exp_q.push_back(8'hA5);
    check("a5_count", bus.count, 1);
    check("a5_int0", bus.int0, 1);
    bus.irq_en = 1'b0;
    #1;
    check("a5_int0_masked", bus.int0, 0);
    bus.irq_en = 1'b1;
    repeat (CPB) @(negedge clk);
    read_byte("a5_data");
    check("a5_count_after_pop", bus.count, 0);
    check("a5_int0_after_pop", bus.int0, 0);
    check("empty_rd_data", bus.rd_data, 0);
    read_byte("underflow_rd_data");
    check("underflow_count", bus.count, 0);

    // One-cycle glitch.
    uart_in = 1'b0;
    @(negedge clk);
    uart_in = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_count", bus.count, 0);
    check("glitch_frame_err", bus.frame_err, 0);
    check("glitch_overrun", bus.overrun, 0);

    // Framing error with long break.
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_set", bus.frame_err, 1);
    check("ferr_count", bus.count, 0);
    $display("tx byte 0x3c with low stop bit");
    uart_in = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h11);
    check("after_ferr_count", bus.count, 1);
    check("ferr_sticky", bus.frame_err, 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("ferr_cleared", bus.frame_err, 0);
    read_byte("after_ferr_data");

    // Reset in mid-frame abandons it.
    uart_in = 1'b0;
    repeat (10) @(negedge clk);
    rst     = 1'b1;
    uart_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("midreset_count", bus.count, 0);
    check("midreset_frame_err", bus.frame_err, 0);

    // Table: fill past depth.
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      check($sformatf("vec%0d_overrun", i), bus.overrun, vecs[i].exp_ovr);
      check($sformatf("vec%0d_frame_err", i), bus.frame_err, vecs[i].exp_ferr);
    end
    for (int i = 0; i < 4; i++) begin
      read_byte($sformatf("ovr_read%0d", i));
      check($sformatf("ovr_read%0d_count", i), bus.count, 3 - i);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("ovr_cleared", bus.overrun, 0);

    send_byte(8'h06);
    send_byte(8'h07);
    check("wrap_count", bus.count, 2);
    read_byte("wrap_read06");
    read_byte("wrap_read07");

    // Push and pop together while full.
    send_byte(8'h08);
    send_byte(8'h09);
    send_byte(8'h0A);
    send_byte(8'h0B);
    check("full_count", bus.count, 4);
    send_frame(8'h0C, 1'b1);
    check("pp_head_before", bus.rd_data, exp_q[0]);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h0C);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    $display("tx byte 0x0c with simultaneous pop");
    check("pp_count", bus.count, 4);
    check("pp_overrun", bus.overrun, 0);
    check("pp_head_after", bus.rd_data, exp_q[0]);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) read_byte($sformatf("pp_drain%0d", i));
    check("final_count", bus.count, 0);
    check("final_int0", bus.int0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end between the board `uart_in` pin and the CPU peripheral bus.
- Synchronises the asynchronous line and deserialises 8N1 frames, LSB first.
- Queues received bytes in a small show-ahead FIFO and raises a level interrupt (`int0`) to the CPU while data is pending.
- The CPU pops bytes with a one-cycle read strobe and clears sticky error flags through a clear strobe.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per bit period; minimum 4, must be even.
- FIFO_AW, 2: FIFO address width; depth is 2**FIFO_AW.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_in  in  1  asynchronous serial line; idles high.
- rd_en  in  1  CPU pop strobe; one byte is popped per cycle it is high.
- irq_en  in  1  interrupt enable.
- err_clr  in  1  clears `overrun` and `frame_err`.
- rd_data  out  8  FIFO head byte (show-ahead); 0 when empty.
- count  out  FIFO_AW+1  number of bytes stored.
- int0  out  1  interrupt: `irq_en` && count != 0.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky flag: a stop bit was sampled low.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; it is sampled on the rising edge of `clk`.
- Reset state:
  - Synchroniser flops are set to 1.
  - FSM goes to IDLE; bit counter and sample counter are 0.
  - FIFO is emptied: `count` = 0 and `rd_data` = 0.
  - `int0`, `overrun` and `frame_err` are 0.
  - A reset asserted mid-frame abandons the frame with no push and no flag.
- Synchroniser: two flops; `rxs` is the second flop. `uart_in` is used nowhere else.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: `rxs` == 0 -> START, sample counter = 0.
  - START: after CLKS_PER_BIT/2 cycles, sample `rxs`.
    - 0 -> DATA, counters reset.
    - 1 -> IDLE (glitch rejected, no flag).
  - DATA: every CLKS_PER_BIT cycles, shift `rxs` into bit[bitcnt], LSB first. After the 8th bit -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - 1 -> push the byte and go to IDLE.
    - 0 -> set `frame_err`, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` == 1, then go to IDLE. A break condition never retriggers START.
- Latency: the byte is visible on `rd_data`/`count` the cycle after the stop-bit sample edge. `int0` follows combinationally from registered `count`.
- FIFO:
  - Circular buffer; read and write pointers are FIFO_AW bits wide and wrap modulo the depth.
  - `count` is a separate register.
  - `rd_en` while empty is ignored: no pointer change, no underflow.
  - Push while full with no pop: the byte is dropped, `overrun` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both happen, `count` is unchanged. This holds even when full (no overrun) and when empty (the new byte is not popped; pop is ignored, `count` goes 0->1).
- `rd_data` = mem[rd_ptr] when count != 0, else 0.
- Flags: `err_clr` clears both flags. If a set event and `err_clr` occur in the same cycle, the set wins.

Test Plan:
- Reset check (CLKS_PER_BIT=4): hold `rst` for 4 cycles with `uart_in`=1 -> `count`=0, `int0`=0, `rd_data`=0, `overrun`=0, `frame_err`=0.
- Single frame: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with `irq_en`=1 -> `count`=1, `rd_data`=0xA5, `int0`=1. Then pulse `rd_en` -> `count`=0, `int0`=0.
- Glitch rejection: drive `uart_in` low for 1 cycle, then high -> FSM returns to IDLE, `count`=0, no flags set.
- Framing error: send 0x3C with the stop bit 0 and hold the line low 20 cycles -> `frame_err`=1, `count`=0, no new frame is started. Release the line, send 0x11 -> `count`=1, `rd_data`=0x11. Pulse `err_clr` -> `frame_err`=0.
- Overrun and wrap: send 0x01..0x05 without reading (depth 4) -> `count`=4, `overrun`=1. Reads return 0x01..0x04 in order. Then send 0x06, 0x07 -> correct values after pointer wrap.
- Simultaneous push/pop when full: with 4 bytes queued, assert `rd_en` on the push cycle -> `count` stays 4, `overrun`=0, head advances by one.
